rr_grant_scheduler: RTL and testbench
=====================================

Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one downstream resource between 8 requesters.
- Each cycle it finds the first asserted request at or after a rotating priority pointer, wrapping around. This is a priority encoder with a moving start point.
- It issues a registered grant and holds it until the owner signals done, or until a hold-time limit expires.
- It sits between the request lines and the shared datapath, and drives the resource's select and enable.

Parameters:
N, 8, number of requesters (index width IDW = 3 for the default)
MAX_HOLD, 16, maximum cycles a grant may be held before forced release (>= 1)
CNT_W, 5, width of hold counter (must hold MAX_HOLD-1)

Ports:
clk  input  1  clock, all state updates on rising edge
areset  input  1  asynchronous active-high reset
req  input  N  request lines, level-sensitive, bit i = requester i
done  input  1  current owner finished; sampled only while gnt_valid=1
gnt_valid  output  1  a grant is active
gnt_id  output  IDW  binary index of granted requester
gnt_onehot  output  N  one-hot grant (all zeros when gnt_valid=0)
timeout  output  1  one-cycle pulse: grant was forcibly released
ptr  output  IDW  current round-robin start pointer (debug/observability)

Behaviour:
- All outputs are registered.
- Reset (async, immediate, also mid-grant):
  - state=IDLE, gnt_valid=0, gnt_id=0, gnt_onehot=0, timeout=0, ptr=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at a rising edge, select winner w = first index i in order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with req[i]=1.
  - Next cycle: gnt_valid=1, gnt_id=w, gnt_onehot=1<<w, hold counter=0, state=GRANT.
  - If req == 0: stay IDLE, outputs unchanged (grant outputs 0).
  - Latency: req seen at edge k gives gnt_valid high from edge k onward (one clock).
- GRANT:
  - Grant is held regardless of req[gnt_id] dropping; only done or timeout releases it.
  - Other req bits are ignored.
  - done=1 at an edge: release. gnt_valid=0, gnt_onehot=0, gnt_id=0, ptr=(gnt_id+1) mod N, state=IDLE.
  - done=0 and hold counter == MAX_HOLD-1 at an edge: forced release, same updates as done, plus timeout=1 for exactly one cycle.
  - Otherwise the hold counter increments.
  - Maximum continuous gnt_valid-high time is MAX_HOLD cycles.
  - done and the timeout condition on the same edge: treated as normal done, timeout stays 0.
- After any release, gnt_valid is low for at least one cycle (the IDLE arbitration cycle). A new grant requires a further edge; there are no back-to-back grants.
- timeout is 0 in every cycle other than the one following a forced release.
- ptr changes only on release and only to (released id + 1) mod N; wrap from N-1 to 0.
- done asserted while IDLE is ignored.
- gnt_onehot always equals decode(gnt_id) when gnt_valid=1.
- Fairness: a continuously asserted requester is granted within N grants.

Test Plan:
- Assert areset mid-simulation with gnt_valid=1, gnt_id=5 -> all outputs 0 immediately, without waiting for clk. After release, req=8'h30 -> gnt_id=4 one cycle later.
- req=8'h01 held, done pulsed 1 cycle at the third grant cycle -> gnt_valid high 3 cycles with gnt_id=0, gnt_onehot=8'h01. Then low 1 cycle, ptr=1, then re-grant id 0 via wrap.
- req=8'h81 held, done pulsed in the first grant cycle each time -> grant sequence 0,7,0,7, each separated by one idle cycle; ptr sequence 1,0,1,0.
- req=8'hFF held, done every grant -> grant sequence 0,1,2,3,4,5,6,7,0 (wrap); gnt_onehot 8'h01, 8'h02, ..., 8'h80, 8'h01.
- req=8'h04 held, done never -> gnt_valid high exactly 16 cycles, then timeout=1 for one cycle with gnt_valid=0, ptr=3. Next grant is id 2 (wraps), timeout back to 0.
- req=8'h04, done and the timeout condition coincide on the 16th grant cycle -> release with timeout=0. Separately, drop req[2] during the grant -> gnt_valid stays 1 until done.

Source files
------------

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: picks the first requester at or after a rotating
// pointer, then holds the grant until done or until the hold limit forces release.
module rr_grant_scheduler #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_i,
    input  logic           areset_i,
    input  logic [N-1:0]   req_i,
    input  logic           done_i,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic [N-1:0]   gnt_onehot_o,
    output logic           timeout_o,
    output logic [IDW-1:0] ptr_o
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           state_q;
    logic             gnt_valid_q;
    logic [IDW-1:0]   gnt_id_q;
    logic [N-1:0]     gnt_onehot_q;
    logic             timeout_q;
    logic [IDW-1:0]   ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IDW-1:0]   win_id_d;
    logic [N-1:0]     win_onehot_d;
    logic [IDW-1:0]   ptr_d;
    logic             hold_expired;

    // Scan from the farthest offset down so the closest request to ptr wins.
    always_comb begin
        int idx;
        win_id_d = '0;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (req_i[idx]) win_id_d = IDW'(idx);
        end
    end

    assign win_onehot_d = N'(1) << win_id_d;
    assign ptr_d        = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
    assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q      <= S_IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_id_q     <= '0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b0;
            ptr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        state_q      <= S_GRANT;
                        gnt_valid_q  <= 1'b1;
                        gnt_id_q     <= win_id_d;
                        gnt_onehot_q <= win_onehot_d;
                        cnt_q        <= '0;
                    end
                end
                S_GRANT: begin
                    // done takes precedence, so a coinciding expiry is a normal release
                    if (done_i || hold_expired) begin
                        state_q      <= S_IDLE;
                        gnt_valid_q  <= 1'b0;
                        gnt_id_q     <= '0;
                        gnt_onehot_q <= '0;
                        ptr_q        <= ptr_d;
                        cnt_q        <= '0;
                        timeout_q    <= ~done_i;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_valid_o  = gnt_valid_q;
    assign gnt_id_o     = gnt_id_q;
    assign gnt_onehot_o = gnt_onehot_q;
    assign timeout_o    = timeout_q;
    assign ptr_o        = ptr_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: expected grants are queued when requests are
// driven and popped when the grant appears.
module tb_rr_grant_scheduler;

    logic       clk_i = 1'b0;
    logic       areset_i;
    logic [7:0] req_i;
    logic       done_i;
    logic       gnt_valid_o;
    logic [2:0] gnt_id_o;
    logic [7:0] gnt_onehot_o;
    logic       timeout_o;
    logic [2:0] ptr_o;

    typedef struct {
        logic [2:0] id;
        logic [2:0] ptr_after;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    rr_grant_scheduler #(.N(8), .MAX_HOLD(16), .CNT_W(5)) dut (
        .clk_i        (clk_i),
        .areset_i     (areset_i),
        .req_i        (req_i),
        .done_i       (done_i),
        .gnt_valid_o  (gnt_valid_o),
        .gnt_id_o     (gnt_id_o),
        .gnt_onehot_o (gnt_onehot_o),
        .timeout_o    (timeout_o),
        .ptr_o        (ptr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        areset_i = 1'b1;
        req_i    = '0;
        done_i   = 1'b0;
        tick();
        tick();
        areset_i = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt_valid_o, gnt_id_o, gnt_onehot_o, timeout_o, ptr_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b id=%0d onehot=%h to=%0b ptr=%0d, need all 0",
                     gnt_valid_o, gnt_id_o, gnt_onehot_o, timeout_o, ptr_o);
        end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++;
        if (gnt_valid_o !== 1'b0 || ptr_o !== 3'd0) begin
            errors++;
            $display("FAIL idle_done_ignored: got valid=%0b ptr=%0d, need 0/0", gnt_valid_o, ptr_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        req_i = 8'h01;
        sb.push_back('{3'd0, 3'd1});
        sb.push_back('{3'd0, 3'd1});
        tick();
        e = sb.pop_front();
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== e.id || gnt_onehot_o !== 8'h01) begin
                errors++;
                $display("FAIL single_hold c%0d: got valid=%0b id=%0d onehot=%h, need 1/%0d/01",
                         c, gnt_valid_o, gnt_id_o, gnt_onehot_o, e.id);
            end
            if (c == 3) done_i = 1'b1;
            tick();
        end
        done_i = 1'b0;
        checks++;
        if (gnt_valid_o !== 1'b0 || ptr_o !== e.ptr_after || gnt_onehot_o !== 8'h00) begin
            errors++;
            $display("FAIL single_release: got valid=%0b ptr=%0d onehot=%h, need 0/%0d/00",
                     gnt_valid_o, ptr_o, gnt_onehot_o, e.ptr_after);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_id_o !== e.id) begin
            errors++;
            $display("FAIL single_wrap: got valid=%0b id=%0d, need 1/%0d", gnt_valid_o, gnt_id_o, e.id);
        end
        done_i = 1'b1;
        req_i  = '0;
        tick();
        done_i = 1'b0;
        $display("test_single done");
    endtask

    task automatic run_rotation(input logic [7:0] req, input string name);
        exp_t e;
        int   n;
        n = sb.size();
        req_i = req;
        tick();
        for (int g = 0; g < n; g++) begin
            e = sb.pop_front();
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== e.id || gnt_onehot_o !== (8'h01 << e.id)) begin
                errors++;
                $display("FAIL %s_grant%0d: got valid=%0b id=%0d onehot=%h, need 1/%0d/%h",
                         name, g, gnt_valid_o, gnt_id_o, gnt_onehot_o, e.id, 8'h01 << e.id);
            end
            done_i = 1'b1;
            tick();
            done_i = 1'b0;
            checks++;
            if (gnt_valid_o !== 1'b0 || ptr_o !== e.ptr_after || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle%0d: got valid=%0b ptr=%0d to=%0b, need 0/%0d/0",
                         name, g, gnt_valid_o, ptr_o, timeout_o, e.ptr_after);
            end
            if (g == n - 1) req_i = '0;
            tick();
        end
    endtask

    task automatic test_pair();
        do_reset();
        for (int g = 0; g < 4; g++)
            sb.push_back((g % 2 == 0) ? '{3'd0, 3'd1} : '{3'd7, 3'd0});
        run_rotation(8'h81, "pair");
        $display("test_pair done");
    endtask

    task automatic test_all();
        do_reset();
        for (int g = 0; g < 9; g++) begin
            exp_t e;
            e.id        = 3'(g % 8);
            e.ptr_after = 3'((g + 1) % 8);
            sb.push_back(e);
        end
        run_rotation(8'hFF, "all");
        $display("test_all done");
    endtask

    task automatic test_timeout(input bit with_done);
        exp_t e;
        int   high;
        do_reset();
        req_i = 8'h04;
        sb.push_back('{3'd2, 3'd3});
        sb.push_back('{3'd2, 3'd3});
        tick();
        e = sb.pop_front();
        high = 0;
        for (int c = 0; c < 40 && gnt_valid_o === 1'b1; c++) begin
            high++;
            if (with_done && high == 16) done_i = 1'b1;
            if (timeout_o !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL hold_to_early: got to=1 at grant cycle %0d, need 0", high);
            end
            tick();
        end
        done_i = 1'b0;
        checks++;
        if (high !== 16 || gnt_id_o !== 3'd0) begin
            errors++;
            $display("FAIL hold_len: got %0d cycles high, need 16", high);
        end
        checks++;
        if (timeout_o !== !with_done || ptr_o !== e.ptr_after || gnt_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_release done=%0b: got to=%0b ptr=%0d valid=%0b, need %0b/%0d/0",
                     with_done, timeout_o, ptr_o, gnt_valid_o, !with_done, e.ptr_after);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_id_o !== e.id || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_regrant: got valid=%0b id=%0d to=%0b, need 1/%0d/0",
                     gnt_valid_o, gnt_id_o, timeout_o, e.id);
        end
        done_i = 1'b1;
        req_i  = '0;
        tick();
        done_i = 1'b0;
        $display("test_timeout with_done=%0b done", with_done);
    endtask

    task automatic test_req_drop();
        do_reset();
        req_i = 8'h04;
        tick();
        req_i = 8'h00;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== 3'd2) begin
                errors++;
                $display("FAIL drop_hold c%0d: got valid=%0b id=%0d, need 1/2", c, gnt_valid_o, gnt_id_o);
            end
            tick();
        end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++;
        if (gnt_valid_o !== 1'b0 || ptr_o !== 3'd3) begin
            errors++;
            $display("FAIL drop_release: got valid=%0b ptr=%0d, need 0/3", gnt_valid_o, ptr_o);
        end
        $display("test_req_drop done");
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        req_i = 8'h20;
        sb.push_back('{3'd4, 3'd0});
        tick();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_id_o !== 3'd5) begin
            errors++;
            $display("FAIL areset_pre: got valid=%0b id=%0d, need 1/5", gnt_valid_o, gnt_id_o);
        end
        #2 areset_i = 1'b1;
        #1;
        checks++;
        if ({gnt_valid_o, gnt_id_o, gnt_onehot_o, timeout_o, ptr_o} !== 16'h0) begin
            errors++;
            $display("FAIL areset_async: got valid=%0b id=%0d onehot=%h to=%0b ptr=%0d, need all 0",
                     gnt_valid_o, gnt_id_o, gnt_onehot_o, timeout_o, ptr_o);
        end
        tick();
        areset_i = 1'b0;
        req_i    = 8'h30;
        tick();
        e = sb.pop_front();
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_id_o !== e.id || gnt_onehot_o !== 8'h10) begin
            errors++;
            $display("FAIL areset_regrant: got valid=%0b id=%0d onehot=%h, need 1/%0d/10",
                     gnt_valid_o, gnt_id_o, gnt_onehot_o, e.id);
        end
        done_i = 1'b1;
        req_i  = '0;
        tick();
        done_i = 1'b0;
        $display("test_async_reset done");
    endtask

    initial begin
        areset_i = 1'b1;
        req_i    = '0;
        done_i   = 1'b0;
        test_reset();
        test_single();
        test_pair();
        test_all();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_req_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
